// File: rtl/pipe_pkg.sv
// Shared PIPE receive-path definitions: generation codes, rate-change FSM states,
// completion status codes and per-generation data-path widths.
package pipe_pkg;

  typedef logic [2:0] gen_t;

  localparam gen_t GEN1 = 3'd1;
  localparam gen_t GEN2 = 3'd2;
  localparam gen_t GEN3 = 3'd3;

  localparam int unsigned GEN1_WIDTH = 8;
  localparam int unsigned GEN2_WIDTH = 16;
  localparam int unsigned GEN3_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_WAIT_PHY = 2'd2,
    ST_SETTLE   = 2'd3
  } rate_state_e;

  typedef enum logic [1:0] {
    DS_OK      = 2'd0,
    DS_TIMEOUT = 2'd1,
    DS_BADGEN  = 2'd2
  } done_status_e;

  // Rx data-path width for a generation; 0 for an illegal code.
  function automatic int unsigned gen_width(input gen_t gen);
    case (gen)
      GEN1:    gen_width = GEN1_WIDTH;
      GEN2:    gen_width = GEN2_WIDTH;
      GEN3:    gen_width = GEN3_WIDTH;
      default: gen_width = 0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_rx_rate_ctrl.sv
// PIPE receive-path link-speed sequencer: drains Rx traffic, drives Rate, waits for
// PhyStatus, settles, then retargets GEN; RxValid is gated while the PHY switches.
module pipe_rx_rate_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ReqValid,
  input  logic [2:0] ReqGen,
  output logic       ReqReady,
  input  logic       RxValid,
  input  logic       PhyStatus,
  output logic [1:0] Rate,
  output logic [2:0] GEN,
  output logic       RxValidOut,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] DoneStatus
);

  localparam int unsigned MAX_A = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  rate_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  gen_t             gen_q, gen_d, tgt_q, tgt_d;
  logic [1:0]       rate_q, rate_d;
  done_status_e     dstat_q, dstat_d;
  logic             done_q, done_d;
  logic             rdy_q, busy_q;

  logic accept_c, legal_c;

  assign accept_c = ReqValid && rdy_q && (state_q == ST_IDLE);
  assign legal_c  = (ReqGen == GEN1) || (ReqGen == GEN2) || (ReqGen == GEN3);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      gen_q   <= GEN1;
      tgt_q   <= GEN1;
      rate_q  <= 2'd0;
      dstat_q <= DS_OK;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      gen_q   <= gen_d;
      tgt_q   <= tgt_d;
      rate_q  <= rate_d;
      dstat_q <= dstat_d;
      done_q  <= done_d;
      rdy_q   <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next state; a completing drain beats timeout, PhyStatus beats timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c && legal_c && (ReqGen != gen_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!RxValid && (cnt_q == DRAIN_LAST)) state_d = ST_WAIT_PHY;
        else if (tmo_q == TMO_LAST)            state_d = ST_IDLE;
      end
      ST_WAIT_PHY: begin
        if (PhyStatus)              state_d = ST_SETTLE;
        else if (tmo_q == TMO_LAST) state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, rate/generation and completion status
  always_comb begin
    cnt_d   = '0;
    tmo_d   = '0;
    gen_d   = gen_q;
    tgt_d   = tgt_q;
    rate_d  = rate_q;
    dstat_d = dstat_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (!legal_c) begin
            done_d  = 1'b1;
            dstat_d = DS_BADGEN;
          end else if (ReqGen == gen_q) begin
            done_d  = 1'b1;
            dstat_d = DS_OK;
          end else begin
            tgt_d = ReqGen;
          end
        end
      end
      ST_DRAIN: begin
        cnt_d = RxValid ? '0 : cnt_q + CNT_W'(1);
        tmo_d = tmo_q + CNT_W'(1);
        if (state_d == ST_WAIT_PHY) begin
          rate_d = 2'(tgt_q - 3'd1);
          cnt_d  = '0;
          tmo_d  = '0;
        end else if (state_d == ST_IDLE) begin
          done_d  = 1'b1;
          dstat_d = DS_TIMEOUT;
        end
      end
      ST_WAIT_PHY: begin
        tmo_d = tmo_q + CNT_W'(1);
        if (state_d == ST_IDLE) begin
          rate_d  = 2'(gen_q - 3'd1);
          done_d  = 1'b1;
          dstat_d = DS_TIMEOUT;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d == ST_IDLE) begin
          gen_d   = tgt_q;
          done_d  = 1'b1;
          dstat_d = DS_OK;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign RxValidOut = RxValid && (state_q != ST_WAIT_PHY) && (state_q != ST_SETTLE);
  assign ReqReady   = rdy_q;
  assign Rate       = rate_q;
  assign GEN        = gen_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign DoneStatus = dstat_q;

endmodule

// File: tb/tb_pipe_rx_rate_ctrl.sv
// Directed self-checking bench for pipe_rx_rate_ctrl with hand-computed expectations.
module tb_pipe_rx_rate_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ReqValid;
  logic [2:0] ReqGen;
  logic       ReqReady;
  logic       RxValid;
  logic       PhyStatus;
  logic [1:0] Rate;
  logic [2:0] GEN;
  logic       RxValidOut;
  logic       Busy;
  logic       Done;
  logic [1:0] DoneStatus;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_rx_rate_ctrl #(
    .DRAIN_CYCLES  (2),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ReqValid  (ReqValid),
    .ReqGen    (ReqGen),
    .ReqReady  (ReqReady),
    .RxValid   (RxValid),
    .PhyStatus (PhyStatus),
    .Rate      (Rate),
    .GEN       (GEN),
    .RxValidOut(RxValidOut),
    .Busy      (Busy),
    .Done      (Done),
    .DoneStatus(DoneStatus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    ReqValid  = 1'b0;
    ReqGen    = 3'd0;
    RxValid   = 1'b0;
    PhyStatus = 1'b0;

    // Reset
    step();
    chk("rst_gen",   32'(GEN), 1);
    chk("rst_rate",  32'(Rate), 0);
    chk("rst_ready", 32'(ReqReady), 0);
    chk("rst_busy",  32'(Busy), 0);
    chk("rst_done",  32'(Done), 0);
    chk("rst_dstat", 32'(DoneStatus), 0);
    reset = 1'b1;
    step();
    chk("ready_after_rst", 32'(ReqReady), 1);
    RxValid = 1'b1; #1;
    chk("idle_pass_1", 32'(RxValidOut), 1);
    RxValid = 1'b0; #1;
    chk("idle_pass_0", 32'(RxValidOut), 0);

    // Gen1 -> Gen3, best case
    ReqValid = 1'b1; ReqGen = 3'd3;
    step();                                 // t0
    ReqValid = 1'b0;
    chk("g13_busy",  32'(Busy), 1);
    chk("g13_ready", 32'(ReqReady), 0);
    step();                                 // t0+1
    chk("g13_rate_t1", 32'(Rate), 0);
    step();                                 // t0+2
    chk("g13_rate_t2", 32'(Rate), 2);
    RxValid = 1'b1; #1;
    chk("g13_gate_wait", 32'(RxValidOut), 0);
    RxValid = 1'b0;
    PhyStatus = 1'b1;
    step();                                 // t0+3
    PhyStatus = 1'b0;
    RxValid = 1'b1; #1;
    chk("g13_gate_settle", 32'(RxValidOut), 0);
    RxValid = 1'b0;
    step(); step(); step();                 // t0+6
    chk("g13_gen_t6",  32'(GEN), 1);
    chk("g13_done_t6", 32'(Done), 0);
    RxValid = 1'b1; #1;
    chk("g13_gate_t6", 32'(RxValidOut), 0);
    RxValid = 1'b0;
    step();                                 // t0+7
    chk("g13_gen_t7",   32'(GEN), 3);
    chk("g13_done_t7",  32'(Done), 1);
    chk("g13_dstat_t7", 32'(DoneStatus), 0);
    chk("g13_busy_t7",  32'(Busy), 0);
    RxValid = 1'b1; #1;
    chk("g13_pass_t7", 32'(RxValidOut), 1);
    RxValid = 1'b0;
    step();
    chk("g13_done_pulse", 32'(Done), 0);

    // Back to Gen1
    reset = 1'b0; step(); reset = 1'b1; step();
    chk("rst2_gen", 32'(GEN), 1);

    // Gen1 -> Gen2 with RxValid 1,0,1,0,0 during drain
    ReqValid = 1'b1; ReqGen = 3'd2;
    step();                                 // t0
    ReqValid = 1'b0;
    RxValid = 1'b1; #1;
    chk("g12_drain_pass", 32'(RxValidOut), 1);
    step();                                 // t0+1
    RxValid = 1'b0;
    step();                                 // t0+2
    RxValid = 1'b1; #1;
    chk("g12_drain_pass2", 32'(RxValidOut), 1);
    step();                                 // t0+3: completion cancelled
    chk("g12_rate_t3", 32'(Rate), 0);
    chk("g12_busy_t3", 32'(Busy), 1);
    RxValid = 1'b0;
    step();                                 // t0+4
    chk("g12_rate_t4", 32'(Rate), 0);
    step();                                 // t0+5
    chk("g12_rate_t5", 32'(Rate), 1);
    step(); step();                         // t0+7
    PhyStatus = 1'b1;
    step();                                 // t0+8 SETTLE
    PhyStatus = 1'b0;
    step(); step(); step();                 // t0+11
    chk("g12_gen_pre", 32'(GEN), 1);
    step();                                 // t0+12
    chk("g12_gen",   32'(GEN), 2);
    chk("g12_done",  32'(Done), 1);
    chk("g12_dstat", 32'(DoneStatus), 0);

    // Gen2 -> Gen3, PHY never acknowledges
    ReqValid = 1'b1; ReqGen = 3'd3;
    step();                                 // t0
    ReqValid = 1'b0;
    step(); step();                         // t0+2
    chk("tmo_rate_sw", 32'(Rate), 2);
    repeat (1023) step();                   // t0+1025
    chk("tmo_rate_pre", 32'(Rate), 2);
    chk("tmo_busy_pre", 32'(Busy), 1);
    chk("tmo_done_pre", 32'(Done), 0);
    step();                                 // t0+1026
    chk("tmo_rate",  32'(Rate), 1);
    chk("tmo_gen",   32'(GEN), 2);
    chk("tmo_done",  32'(Done), 1);
    chk("tmo_dstat", 32'(DoneStatus), 1);
    chk("tmo_busy",  32'(Busy), 0);

    // Illegal gen, then same gen
    step();
    ReqValid = 1'b1; ReqGen = 3'd0;
    step();
    ReqValid = 1'b0;
    chk("bad_done",  32'(Done), 1);
    chk("bad_dstat", 32'(DoneStatus), 2);
    chk("bad_busy",  32'(Busy), 0);
    chk("bad_rate",  32'(Rate), 1);
    step();
    chk("bad_done_clr",  32'(Done), 0);
    chk("bad_dstat_hold", 32'(DoneStatus), 2);
    ReqValid = 1'b1; ReqGen = 3'd7;
    step();
    ReqValid = 1'b0;
    chk("bad7_dstat", 32'(DoneStatus), 2);
    step();
    ReqValid = 1'b1; ReqGen = 3'd2;
    step();
    ReqValid = 1'b0;
    chk("same_done",  32'(Done), 1);
    chk("same_dstat", 32'(DoneStatus), 0);
    chk("same_busy",  32'(Busy), 0);
    chk("same_rate",  32'(Rate), 1);
    chk("same_gen",   32'(GEN), 2);
    step();
    chk("same_busy2", 32'(Busy), 0);

    // Reset during SETTLE
    ReqValid = 1'b1; ReqGen = 3'd3;
    step();                                 // t0
    ReqValid = 1'b0;
    step(); step();                         // t0+2
    PhyStatus = 1'b1;
    step();                                 // t0+3 SETTLE
    PhyStatus = 1'b0;
    step();                                 // t0+4
    reset = 1'b0;
    step();
    chk("abort_gen",  32'(GEN), 1);
    chk("abort_rate", 32'(Rate), 0);
    chk("abort_done", 32'(Done), 0);
    chk("abort_busy", 32'(Busy), 0);
    reset = 1'b1;
    step();
    chk("abort_ready", 32'(ReqReady), 1);
    chk("abort_done2", 32'(Done), 0);
    step(); step(); step();
    chk("abort_done3", 32'(Done), 0);
    chk("abort_gen3",  32'(GEN), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_rx_rate_ctrl.md
# pipe_rx_rate_ctrl

Sequences PCIe link-speed changes for the PIPE receive path. It accepts a target generation from the LTSSM and drains in-flight receive traffic. It then drives the PIPE Rate signal and waits for the PHY's PhyStatus acknowledge. Only after a settle interval does it retarget `GEN` of the PIPE Rx data path (Gen1/8-bit, Gen2/16-bit, Gen3/32-bit). It sits between the LTSSM and the Rx data path, and gates `RxValid` while the PHY is switching.

## Interface
- `DRAIN_CYCLES`, 2: consecutive `RxValid`=0 cycles required before switching.
- `SETTLE_CYCLES`, 4: cycles held after PhyStatus before releasing the gate.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent in DRAIN or WAIT_PHY.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `ReqValid` in 1: rate-change request.
- `ReqGen` in 3: target generation; 1..3 legal.
- `ReqReady` out 1: high only in IDLE.
- `RxValid` in 1: raw PHY RxValid.
- `PhyStatus` in 1: PHY rate-change acknowledge pulse.
- `Rate` out 2: PIPE Rate to PHY; equals GEN−1.
- `GEN` out 3: generation for the Rx data path.
- `RxValidOut` out 1: `RxValid` when not gated, else 0.
- `Busy` out 1: state ≠ IDLE.
- `Done` out 1: one-cycle completion pulse.
- `DoneStatus` out 2: 0 OK, 1 timeout, 2 illegal gen. Valid only with `Done`; holds its last value otherwise.

## Operation
- States: IDLE, DRAIN, WAIT_PHY, SETTLE.
- Acceptance occurs when `ReqValid`&`ReqReady` are high at a rising edge.
- IDLE, illegal `ReqGen` (0 or 4..7): stay in IDLE; next cycle `Done`=1 with `DoneStatus`=2. `GEN` and `Rate` are unchanged.
- IDLE, `ReqGen`==`GEN`: stay in IDLE; next cycle `Done`=1 with `DoneStatus`=0. No PHY handshake.
- IDLE, otherwise: latch target and go to DRAIN.
- DRAIN:
  - Quiet counter increments when `RxValid`=0 and clears when `RxValid`=1.
  - At count == `DRAIN_CYCLES`, go to WAIT_PHY; `Rate` ← target−1 on that same edge.
  - `RxValidOut` passes through unchanged.
- WAIT_PHY:
  - `RxValidOut`=0.
  - `PhyStatus`=1 goes to SETTLE.
  - `PhyStatus` is sampled only in this state; it is ignored in all others.
- SETTLE:
  - `RxValidOut`=0.
  - After `SETTLE_CYCLES` cycles, go to IDLE; `GEN` ← target on that same edge.
  - `Done`=1 with `DoneStatus`=0 in the first IDLE cycle.
- Timeout:
  - A single timeout counter clears on entry to DRAIN and to WAIT_PHY.
  - Reaching `TIMEOUT_CYCLES` in DRAIN goes to IDLE; `Rate` was never changed.
  - Reaching `TIMEOUT_CYCLES` in WAIT_PHY goes to IDLE; `Rate` reverts to `GEN`−1.
  - In both cases `GEN` is unchanged, and `Done`=1 with `DoneStatus`=1 next cycle.
- `ReqValid` outside IDLE is ignored. The requester holds it until `ReqReady`.

## Timing
- Reset values (`reset`=0 at an edge): state IDLE, `GEN`=1, `Rate`=0, `Done`=0, `DoneStatus`=0, `Busy`=0, `ReqReady`=0 in the reset cycle and then 1, counters 0.
- Reset mid-change: abort immediately to reset values; no `Done` is issued.
- `RxValidOut` is combinational from `RxValid` and the registered state: zero added latency when passing.
- All other outputs are registered.
- Best-case latency for a real change: acceptance edge t0, `RxValid`=0 throughout, `PhyStatus` in the first WAIT_PHY cycle.
  - `Rate` updates at t0+`DRAIN_CYCLES`.
  - SETTLE is entered at t0+`DRAIN_CYCLES`+1.
  - `GEN` updates and `Done` pulses at t0+`DRAIN_CYCLES`+1+`SETTLE_CYCLES`.
- Simultaneous `PhyStatus` and timeout terminal count in WAIT_PHY: `PhyStatus` wins.
- `RxValid`=1 in the same cycle the drain count would complete: the counter clears; no switch.

## Structure
- Shared `pipe_pkg` holds:
  - Generation constants GEN1=1, GEN2=2, GEN3=3.
  - The state enum.
  - DoneStatus codes OK/TIMEOUT/BADGEN.
  - Width-per-gen constants 8/16/32.
- No sub-module: one FSM with a shared cycle counter. Counter width is clog2 of the largest parameter plus 1.

## Test plan
- Reset with `reset`=0 for 1 cycle → `GEN`=1, `Rate`=0, `ReqReady`=1 afterwards, `RxValidOut` follows `RxValid`.
- Gen1→Gen3 with `RxValid`=0 and `PhyStatus` pulsed in the 1st WAIT_PHY cycle → `Rate`=2 at t0+2, `GEN`=3 and `Done`/`DoneStatus`=0 at t0+7, `RxValidOut`=0 from t0+2 to t0+6.
- Gen1→Gen2 with `RxValid` toggling 1,0,1,0,0 → the switch waits for 2 consecutive quiet cycles; data during DRAIN appears on `RxValidOut`.
- Gen2→Gen3 with no `PhyStatus` → after 1024 WAIT_PHY cycles `Rate` returns to 1, `GEN` stays 2, `DoneStatus`=1.
- `ReqGen`=0, then `ReqGen`=current gen → two `Done` pulses with status 2 then 0, `Busy` never set, `Rate` unchanged.
- `reset` asserted during SETTLE → `GEN`=1, `Rate`=0, no `Done` pulse.
